// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, reset vector,
// the break word substituted on misaligned fetches, and the next-PC rule.
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] FETCH_RESET_PC    = 32'h0040_0000;
  localparam logic [INSTR_W-1:0] FETCH_BREAK_INSTR = 32'h0000_000D;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_FAULT
  } fetch_state_e;

  // Sequential successor wraps at 32 bits; a redirect overrides it.
  function automatic logic [INSTR_W-1:0] next_pc(
    input logic [INSTR_W-1:0] pc,
    input logic               redir_valid,
    input logic [INSTR_W-1:0] redir_pc
  );
    return redir_valid ? redir_pc : pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage of the multicycle MIPS core: holds the PC, issues one imem
// request at a time and presents the instruction register to the decoder.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC    = FETCH_RESET_PC,
  parameter logic [INSTR_W-1:0] BREAK_INSTR = FETCH_BREAK_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               instr_ack,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] raw_instruction,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] pc_out,
  output logic [INSTR_W-1:0] npc,
  output logic               fetch_misalign
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic               misalign_q, misalign_d;
  logic [INSTR_W-1:0] target;

  assign target = next_pc(pc_q, redirect_valid, redirect_pc);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ:  state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          state_d = FETCH_HOLD;
        end
      end
      FETCH_HOLD, FETCH_FAULT: begin
        // A misaligned target never reaches memory; break is injected instead.
        if (instr_ack) begin
          pc_d = target;
          if (target[1:0] == 2'b00) begin
            valid_d = 1'b0;
            state_d = FETCH_REQ;
          end else begin
            ir_d       = BREAK_INSTR;
            valid_d    = 1'b1;
            misalign_d = 1'b1;
            state_d    = FETCH_FAULT;
          end
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Request is masked by rst so nothing leaks out during the reset cycle.
  assign imem_req        = (state_q == FETCH_REQ) && !rst;
  assign imem_addr       = pc_q;
  assign raw_instruction = ir_q;
  assign instr_valid     = valid_q;
  assign pc_out          = pc_q;
  assign npc             = pc_q + 32'd4;
  assign fetch_misalign  = misalign_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: a driver predicts each
// fetch from the PC rules, a memory model answers requests, a monitor checks.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] BREAK_WORD = 32'h0000_000D;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] raw_instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] npc;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_ack      (instr_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .raw_instruction(raw_instruction),
    .instr_valid    (instr_valid),
    .pc_out         (pc_out),
    .npc            (npc),
    .fetch_misalign (fetch_misalign)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic        misalign;
  } expect_t;

  expect_t     expQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] modelPc;
  int          forceLat   = 0;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h2008_0005;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Model of the fetch contract: every accepted PC is either fetched or faulted.
  function automatic void predict(input logic [31:0] target);
    expect_t e;
    e.addr     = target;
    e.misalign = (target[1:0] != 2'b00);
    e.ir       = e.misalign ? BREAK_WORD : memWord(target);
    expQ.push_back(e);
  endfunction

  // Memory responder with random latency, plus stray rvalid pulses while
  // an instruction is being held.
  initial begin : memoryModel
    int          cnt;
    logic [31:0] reqAddr;
    cnt         = 0;
    reqAddr     = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(reqAddr);
          end
        end else if (instr_valid && $urandom_range(0, 2) == 0) begin
          imem_rvalid = 1'b1;
        end
        if (imem_req) begin
          reqAddr  = imem_addr;
          cnt      = (forceLat != 0) ? forceLat : $urandom_range(1, 5);
          forceLat = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new presentation, checks requests.
  initial begin : monitor
    logic    prevValid, prevReq, newPres;
    logic [31:0] heldIr, heldPc;
    expect_t e;
    prevValid = 1'b0;
    prevReq   = 1'b0;
    heldIr    = '0;
    heldPc    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid = 1'b0;
        prevReq   = 1'b0;
      end else begin
        if (imem_req) begin
          checkOutput("imem_req single cycle", 32'(prevReq), 32'd0);
          if (expQ.size() == 0) begin
            checkOutput("unexpected imem_req", 32'(imem_req), 32'd0);
          end else begin
            checkOutput("imem_addr", imem_addr, expQ[0].addr);
            checkOutput("req pc_out", pc_out, expQ[0].addr);
            checkOutput("req on aligned target", 32'(imem_req), 32'(!expQ[0].misalign));
          end
        end
        newPres = instr_valid && (!prevValid || fetch_misalign);
        if (newPres) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected instruction", 32'(instr_valid), 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("raw_instruction", raw_instruction, e.ir);
            checkOutput("pc_out", pc_out, e.addr);
            checkOutput("npc", npc, e.addr + 32'd4);
            checkOutput("fetch_misalign pulse", 32'(fetch_misalign), 32'(e.misalign));
            heldIr = e.ir;
            heldPc = e.addr;
          end
        end else begin
          checkOutput("fetch_misalign idle", 32'(fetch_misalign), 32'd0);
          if (instr_valid) begin
            checkOutput("IR stable", raw_instruction, heldIr);
            checkOutput("pc stable", pc_out, heldPc);
          end
        end
        prevValid = instr_valid;
        prevReq   = imem_req;
      end
    end
  end

  // Release from reset with a 1-cycle memory: req in cycle 1, valid in cycle 3.
  task automatic checkStartup();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkOutput($sformatf("startup imem_req c%0d", n), 32'(imem_req), 32'(n == 1));
      if (n >= 2)
        checkOutput($sformatf("startup instr_valid c%0d", n), 32'(instr_valid), 32'(n == 3));
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset raw_instruction", raw_instruction, 32'd0);
    checkOutput("reset pc_out", pc_out, RESET_VEC);
    checkOutput("reset npc", npc, RESET_VEC + 32'd4);
    checkOutput("reset imem_req", 32'(imem_req), 32'd0);
    checkOutput("reset fetch_misalign", 32'(fetch_misalign), 32'd0);
    expQ.delete();
    modelPc = RESET_VEC;
    predict(modelPc);
    forceLat = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkStartup();
  endtask

  // Waits for a held instruction, then acknowledges it with an optional redirect.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      checkOutput("instr_valid before ack", 32'(instr_valid), 32'd1);
      return;
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(posedge clk);
    #1;
    instr_ack      = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    modelPc        = redir ? rpc : modelPc + 32'd4;
    predict(modelPc);
    @(posedge clk);
    #1;
    instr_ack      = 1'b0;
    redirect_valid = $urandom_range(0, 1) == 1;
    redirect_pc    = $urandom;
  endtask

  task automatic randomAck();
    int          r;
    logic [1:0]  lo;
    logic [31:0] w;
    r  = $urandom_range(0, 9);
    lo = 2'($urandom_range(1, 3));
    w  = $urandom;
    if (r < 6)       applyStimulus(1'b0, w);
    else if (r < 8)  applyStimulus(1'b1, RESET_VEC + 32'($urandom_range(0, 255) * 4));
    else if (r == 8) applyStimulus(1'b1, {w[31:2], lo});
    else             applyStimulus(1'b1, 32'hFFFF_FFFC);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCount);
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    int n;
    rst            = 1'b1;
    instr_ack      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    modelPc        = RESET_VEC;
    @(posedge clk);
    #1;
    doReset();

    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0040_0100);
    applyStimulus(1'b1, 32'h0040_0102);
    applyStimulus(1'b1, 32'h0040_0004);
    applyStimulus(1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0);

    for (int i = 0; i < 40; i++) randomAck();

    // Reset while the fetch is parked in WAIT behind a slow memory.
    applyStimulus(1'b1, 32'h0040_0200);
    forceLat = 5;
    applyStimulus(1'b0, 32'h0);
    @(posedge clk);
    #1;
    doReset();

    for (int i = 0; i < 20; i++) randomAck();

    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the 54-instruction multicycle MIPS core; sits directly upstream of the instruction decoder.
- Holds the PC, issues one request at a time to instruction memory, and latches the returned word into the instruction register (IR).
- Presents IR and a valid flag to the decoder; raw_instruction feeds the decoder's instruction input and instr_valid drives its enable.
- Advances only when the control unit acknowledges completion; takes a redirect target for jumps, branches and exceptions.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- BREAK_INSTR, 32'h0000_000D, word substituted into IR on a misaligned fetch; it decodes as break.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request; high for exactly one cycle per fetch.
- imem_addr  out  32  fetch address; equals pc_out.
- imem_rvalid  in  1  read data valid; never earlier than the cycle after imem_req.
- imem_rdata  in  32  instruction word returned by memory.
- instr_ack  in  1  control unit has finished the current instruction.
- redirect_valid  in  1  the next PC is redirect_pc; sampled only together with instr_ack.
- redirect_pc  in  32  jump, branch or exception target.
- raw_instruction  out  32  IR contents.
- instr_valid  out  1  IR holds a live instruction.
- pc_out  out  32  PC of the instruction in IR.
- npc  out  32  pc_out + 4, combinational, used for jal/jalr/branch base.
- fetch_misalign  out  1  one-cycle pulse when a misaligned target is rejected.

Behaviour:
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT. State and all registers are updated on the rising clk edge only.
- Reset (rst=1 at an edge):
  - state=IDLE, pc=RESET_PC, IR=0, instr_valid=0, fetch_misalign=0.
  - imem_req is 0 while in IDLE and while rst is high.
  - Reset mid-fetch discards everything. imem shares rst, so no response survives reset.
- IDLE: go to REQ on the next cycle unconditionally.
- REQ:
  - imem_req=1, imem_addr=pc. Go to WAIT.
  - imem_rvalid seen in REQ is ignored.
- WAIT:
  - imem_req=0. Stay until imem_rvalid=1.
  - On rvalid: IR<=imem_rdata, instr_valid<=1, go to HOLD.
  - There is no timeout.
- HOLD:
  - IR and instr_valid=1 are held stable; imem_rvalid is ignored.
  - On instr_ack: target = redirect_valid ? redirect_pc : pc+4 (32-bit wrap, carry dropped), instr_valid<=0.
  - If target[1:0]==0: pc<=target, go to REQ.
  - Else: pc<=target, IR<=BREAK_INSTR, fetch_misalign<=1 for one cycle, instr_valid<=1, go to FAULT. No memory request is issued.
- FAULT:
  - Behaves as HOLD: IR=BREAK_INSTR is valid, and pc_out shows the faulting target for EPC/BadVAddr.
  - On instr_ack: the same target rule applies. The exception handler redirect is expected here.
- Outside HOLD/FAULT, instr_ack and redirect_valid are ignored.
- Simultaneous rst and any other input: rst wins.
- Latency:
  - Ack in HOLD at cycle t gives imem_req at t+1.
  - With rvalid at t+2, instr_valid=1 at t+3.
  - From reset release, imem_req comes at cycle 1 (IDLE occupies cycle 0).
- Invariants:
  - instr_valid=1 exactly in HOLD and FAULT.
  - At most one outstanding request.
  - pc_out and IR change only on the state transitions listed above.

Decomposition:
- Shared package holds:
  - fetch state encoding (IDLE, REQ, WAIT, HOLD, FAULT);
  - RESET_PC default;
  - BREAK_INSTR constant;
  - INSTR_W=32.
- No sub-module is needed. The pc+4 / redirect next-PC mux stays inline; it may be split into fetch_next_pc if reused by exception logic.

Test Plan:
1. Reset then sequential run: memory returns 32'h2008_0005 with 1-cycle latency, ack each instruction → imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_valid first high at cycle 3.
2. Variable latency: rvalid 5 cycles after req, with a spurious rvalid asserted during HOLD → IR captures only the WAIT-state data; HOLD value unchanged by the spurious pulse.
3. Redirect: ack with redirect_valid=1, redirect_pc=0x00400100 → next imem_addr=0x00400100, pc_out=0x00400100, npc=0x00400104.
4. Misaligned redirect to 0x00400102 → no imem_req, fetch_misalign pulses once, IR=0x0000000D, pc_out=0x00400102; then ack with redirect 0x00400004 → fetch resumes at 0x00400004.
5. Reset asserted while in WAIT → all outputs return to reset values next cycle; first post-reset fetch address is 0x00400000.
6. Wrap: ack with redirect_pc=0xFFFFFFFC, then ack with no redirect → next fetch address 0x00000000.
